hard_mem_1rw_byte_mask_arbiter: RTL and testbench
=================================================

# hard_mem_1rw_byte_mask_arbiter

Shares one single-port, byte-masked SRAM wrapper (default 512 x 64, 1-cycle registered-address read) among `num_req_p` requesters. Uses round-robin arbitration and issues at most one access per cycle. Routes each read result back to the requester that issued it. Optionally zero-fills the array after reset before granting any requests. Sits between cache/queue clients and a hardened `hard_mem_1rw_byte_mask_*` macro wrapper.

## Interface
Parameters:
- `width_p`, 64, data width in bits; must be a multiple of 8.
- `els_p`, 512, number of memory words.
- `num_req_p`, 2, number of requesters (≥ 2).
- `addr_width_lp`, `$clog2(els_p)`, derived.
- `write_mask_width_lp`, `width_p>>3`, derived.

Ports. One clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `v_i`  in  `num_req_p`  per-requester request valid.
- `w_i`  in  `num_req_p`  per-requester write (1) / read (0).
- `addr_i`  in  `num_req_p*addr_width_lp`  packed addresses.
- `data_i`  in  `num_req_p*width_p`  packed write data.
- `write_mask_i`  in  `num_req_p*write_mask_width_lp`  packed byte enables.
- `ready_o`  out  `num_req_p`  one-hot grant; a request is accepted when `v_i[k] & ready_o[k]`.
- `v_o`  out  `num_req_p`  one-hot read-response valid.
- `data_o`  out  `width_p`  read data, meaningful only while `|v_o`.
- `init_done_o`  out  1  high once the arbiter accepts requests.
- `mem_v_o`, `mem_w_o`  out  1 each  memory enable and write.
- `mem_addr_o`  out  `addr_width_lp`  memory address.
- `mem_data_o`  out  `width_p`  memory write data.
- `mem_write_mask_o`  out  `write_mask_width_lp`  memory byte enables.
- `mem_data_i`  in  `width_p`  memory read data, valid the cycle after a read.

## Operation
- State machine: `eINIT` → `eRUN`. Reset value is `eINIT` when the macro is defined and `eRUN` otherwise.
- In `eRUN`, the arbiter grants the highest-priority requester with `v_i` set.
  - Priority begins at the index after the last granted index (round-robin).
  - The pointer advances only on an accepted request. Reset value of the pointer is 0, so requester 0 has first priority.
- `ready_o` is combinational from `v_i`. Requesters must not make `v_i` depend on `ready_o`. At most one bit of `ready_o` is high per cycle.
- On acceptance, the granted requester's `w_i`, `addr_i`, `data_i` and `write_mask_i` drive the `mem_*` outputs in the same cycle, with `mem_v_o` = 1.
  - Reads force `mem_write_mask_o` = 0.
- For an accepted read, a one-hot register `rd_v_r` records the requester index.
  - The next cycle, `v_o` = `rd_v_r` and `data_o` = `mem_data_i` (pass-through, no extra register).
  - There is no response backpressure: the requester must consume the data that cycle.
- Writes produce no response.
- Reads and writes from different requesters may issue back-to-back every cycle.
- With no valid requester: `mem_v_o` = 0, the pointer holds, and the `mem_*` data and address outputs are don't-care.

## Timing
- Reset values: `ready_o` = 0, `v_o` = 0, `mem_v_o` = 0, `mem_w_o` = 0, `rd_v_r` = 0.
  - With the macro, `init_done_o` = 0 during and after reset until init completes. Without it, `init_done_o` = 1.
- Read latency is 1 cycle, from the acceptance edge to `v_o`.
- Throughput is 1 access per cycle.
- Reset asserted while a read response is pending: the response is dropped and `v_o` = 0 on the next cycle.
- A read accepted in the last cycle before reset asserts still returns nothing.

## Configuration
- Macro: `HARD_MEM_1RW_ARB_ZERO_INIT_EN`.
- Defined:
  - In `eINIT`, a counter sweeps addresses 0 to `els_p-1`, one per cycle, writing all-zero data with a full mask. `mem_v_o` = `mem_w_o` = 1 and `ready_o` = 0 throughout.
  - On the cycle after address `els_p-1` is written, the state becomes `eRUN` and `init_done_o` rises.
  - Reset mid-sweep restarts at address 0.
  - The sweep takes exactly `els_p` cycles after reset deasserts.
- Undefined: no counter and no `eINIT` state. Requests are accepted on the first cycle after reset deasserts.

## Structure
- Package `hard_mem_1rw_arb_pkg`: state enum (`eINIT`, `eRUN`) and a `req_idx_width(n)` constant function.
- Sub-module `hard_mem_1rw_arb_rr`: an N-way round-robin grant generator with inputs `reqs_i` and `yumi_i` and outputs one-hot `grants_o`. It owns the pointer.
- Top-level module: FSM, init counter, muxing, `rd_v_r`.

## Test plan
- Reset with the macro defined → `mem_w_o` = 1 for 512 consecutive cycles at addresses 0..511 with data 0, `ready_o` = 0, then `init_done_o` = 1. Later reads of any address return 0.
- Requester 0 writes `0x1122334455667788` to addr 5 with mask `0x0F`, then reads addr 5 → `v_o` = `2'b01`, `data_o` = `0x0000000055667788` one cycle after acceptance.
- Both requesters hold `v_i` high with reads for 4 cycles → grants alternate 0, 1, 0, 1; `v_o` alternates one cycle later with the correct data.
- Requester 1 alone streams 3 reads → `ready_o[1]` = 1 every cycle and the pointer still advances. Requester 0 then arrives together with requester 1 → requester 0 is granted first.
- Read accepted, then reset asserted on the next edge → `v_o` = 0 on that cycle. With the macro defined, the sweep restarts at addr 0.
- Reset asserted at sweep address 200 → after deassert, the sweep restarts at 0 and `init_done_o` rises 512 cycles later.

Source files
------------

// File: rtl/hard_mem_1rw_arb_pkg.sv
// Shared types and helpers for the byte-masked 1RW memory arbiter.
package hard_mem_1rw_arb_pkg;

  typedef enum logic {
    eINIT = 1'b0,
    eRUN  = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned req_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hard_mem_1rw_arb_rr.sv
// N-way round-robin grant generator; the pointer names the highest-priority requester.
module hard_mem_1rw_arb_rr
  import hard_mem_1rw_arb_pkg::*;
#(
  parameter int unsigned num_req_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] reqs_i,
  input  logic                 yumi_i,
  output logic [num_req_p-1:0] grants_o
);

  localparam int unsigned idx_width_lp = req_idx_width(num_req_p);
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_req_p - 1);
  localparam logic [idx_width_lp-1:0] one_lp      = idx_width_lp'(1);

  logic [idx_width_lp-1:0] ptr_r, ptr_n, scan_idx, gnt_idx;
  logic                    found;

  // Scan from the pointer upward with wrap; first requester found wins.
  always_comb begin
    grants_o = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_idx = ptr_r;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (!found && reqs_i[scan_idx]) begin
        found   = 1'b1;
        gnt_idx = scan_idx;
      end
      scan_idx = (scan_idx == last_idx_lp) ? '0 : scan_idx + one_lp;
    end
    if (found) grants_o[gnt_idx] = 1'b1;
    ptr_n = (gnt_idx == last_idx_lp) ? '0 : gnt_idx + one_lp;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_r <= '0;
    end else if (yumi_i && found) begin
      ptr_r <= ptr_n;
    end
  end

endmodule

// File: rtl/hard_mem_1rw_byte_mask_arbiter.sv
// Round-robin sharing of one byte-masked 1RW SRAM wrapper among num_req_p requesters.
// Define HARD_MEM_1RW_ARB_ZERO_INIT_EN to zero-fill the array after reset before granting.
module hard_mem_1rw_byte_mask_arbiter
  import hard_mem_1rw_arb_pkg::*;
#(
  parameter int unsigned width_p             = 64,
  parameter int unsigned els_p               = 512,
  parameter int unsigned num_req_p           = 2,
  parameter int unsigned addr_width_lp       = $clog2(els_p),
  parameter int unsigned write_mask_width_lp = width_p >> 3
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_req_p-1:0]                     v_i,
  input  logic [num_req_p-1:0]                     w_i,
  input  logic [num_req_p*addr_width_lp-1:0]       addr_i,
  input  logic [num_req_p*width_p-1:0]             data_i,
  input  logic [num_req_p*write_mask_width_lp-1:0] write_mask_i,
  output logic [num_req_p-1:0]                     ready_o,
  output logic [num_req_p-1:0]                     v_o,
  output logic [width_p-1:0]                       data_o,
  output logic                                     init_done_o,
  output logic                                     mem_v_o,
  output logic                                     mem_w_o,
  output logic [addr_width_lp-1:0]                 mem_addr_o,
  output logic [width_p-1:0]                       mem_data_o,
  output logic [write_mask_width_lp-1:0]           mem_write_mask_o,
  input  logic [width_p-1:0]                       mem_data_i
);

  logic                           run, in_init;
  logic [addr_width_lp-1:0]       init_addr;
  logic [num_req_p-1:0]           reqs, grants, rd_v_r;
  logic                           sel_w;
  logic [addr_width_lp-1:0]       sel_addr;
  logic [width_p-1:0]             sel_data;
  logic [write_mask_width_lp-1:0] sel_mask;

`ifdef HARD_MEM_1RW_ARB_ZERO_INIT_EN
  arb_state_e               state_r, state_n;
  logic [addr_width_lp-1:0] init_addr_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= eINIT;
      init_addr_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == eINIT) init_addr_r <= init_addr_r + addr_width_lp'(1);
    end
  end

  // Leave the sweep once the last word has been written.
  always_comb begin
    state_n = state_r;
    if ((state_r == eINIT) && (init_addr_r == addr_width_lp'(els_p - 1))) state_n = eRUN;
  end

  assign in_init     = (state_r == eINIT) && !reset_i;
  assign run         = (state_r == eRUN) && !reset_i;
  assign init_addr   = init_addr_r;
  assign init_done_o = run;
`else
  assign in_init     = 1'b0;
  assign run         = !reset_i;
  assign init_addr   = '0;
  assign init_done_o = 1'b1;
`endif

  assign reqs    = v_i & {num_req_p{run}};
  assign ready_o = grants;

  hard_mem_1rw_arb_rr #(
    .num_req_p(num_req_p)
  ) rr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .reqs_i  (reqs),
    .yumi_i  (|grants),
    .grants_o(grants)
  );

  // One-hot select of the granted requester's command fields.
  always_comb begin
    sel_w    = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_mask = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (grants[i]) begin
        sel_w    = w_i[i];
        sel_addr = addr_i[i*addr_width_lp +: addr_width_lp];
        sel_data = data_i[i*width_p +: width_p];
        sel_mask = write_mask_i[i*write_mask_width_lp +: write_mask_width_lp];
      end
    end
  end

  always_comb begin
    mem_v_o          = 1'b0;
    mem_w_o          = 1'b0;
    mem_addr_o       = sel_addr;
    mem_data_o       = sel_data;
    mem_write_mask_o = '0;
    if (in_init) begin
      mem_v_o          = 1'b1;
      mem_w_o          = 1'b1;
      mem_addr_o       = init_addr;
      mem_data_o       = '0;
      mem_write_mask_o = '1;
    end else begin
      mem_v_o          = |grants;
      mem_w_o          = (|grants) && sel_w;
      mem_write_mask_o = sel_w ? sel_mask : '0;
    end
  end

  // Remember which requester owns the read in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_v_r <= '0;
    end else begin
      rd_v_r <= grants & ~w_i;
    end
  end

  // A response pending across a reset edge is dropped.
  assign v_o    = rd_v_r & {num_req_p{!reset_i}};
  assign data_o = mem_data_i;

endmodule

// File: tb/tb_hard_mem_1rw_byte_mask_arbiter.sv
// Directed bench for hard_mem_1rw_byte_mask_arbiter with a byte-masked SRAM model.
// Honours HARD_MEM_1RW_ARB_ZERO_INIT_EN when defined for the build.
module tb_hard_mem_1rw_byte_mask_arbiter;

  localparam int unsigned W  = 64;
  localparam int unsigned E  = 512;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 9;
  localparam int unsigned MW = 8;
`ifdef HARD_MEM_1RW_ARB_ZERO_INIT_EN
  localparam bit          ZI       = 1'b1;
  localparam logic [W-1:0] MEM_INIT = 64'hDEAD_BEEF_CAFE_F00D;
`else
  localparam bit          ZI       = 1'b0;
  localparam logic [W-1:0] MEM_INIT = 64'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N-1:0]      v, w, ready, v_o;
  logic [N*AW-1:0]   addr;
  logic [N*W-1:0]    data;
  logic [N*MW-1:0]   mask;
  logic [W-1:0]      data_o, mem_data, mem_rdata;
  logic              init_done, mem_v, mem_w;
  logic [AW-1:0]     mem_addr;
  logic [MW-1:0]     mem_mask;
  logic [W-1:0]      mem [E] = '{default: MEM_INIT};
  logic [W-1:0]      wr_tmp;

  int n_checks = 0;
  int n_fail   = 0;

  hard_mem_1rw_byte_mask_arbiter #(
    .width_p(W), .els_p(E), .num_req_p(N)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .v_i             (v),
    .w_i             (w),
    .addr_i          (addr),
    .data_i          (data),
    .write_mask_i    (mask),
    .ready_o         (ready),
    .v_o             (v_o),
    .data_o          (data_o),
    .init_done_o     (init_done),
    .mem_v_o         (mem_v),
    .mem_w_o         (mem_w),
    .mem_addr_o      (mem_addr),
    .mem_data_o      (mem_data),
    .mem_write_mask_o(mem_mask),
    .mem_data_i      (mem_rdata)
  );

  // SRAM model: byte-masked write, registered read data.
  always @(posedge clk) begin
    if (mem_v) begin
      if (mem_w) begin
        wr_tmp = mem[mem_addr];
        for (int b = 0; b < int'(MW); b++) begin
          if (mem_mask[b]) wr_tmp[8*b +: 8] = mem_data[8*b +: 8];
        end
        mem[mem_addr] <= wr_tmp;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic valid, input logic wr, input logic [AW-1:0] a,
                     input logic [W-1:0] d, input logic [MW-1:0] m);
    v[k]              = valid;
    w[k]              = wr;
    addr[k*AW +: AW]  = a;
    data[k*W +: W]    = d;
    mask[k*MW +: MW]  = m;
  endtask

  // Walks the full zero-fill, starting in the cycle right after reset deasserts.
  task automatic sweep_check(input string tag);
    int bad;
    bad = 0;
    v   = 2'b11;
    for (int i = 0; i < int'(E); i++) begin
      #1;
      if (!(mem_v && mem_w && mem_addr == AW'(i) && mem_data == '0 && mem_mask == '1 &&
            ready == '0 && !init_done)) bad++;
      tick();
    end
    check_eq(tag, 64'(bad), 64'(0));
    #1;
    check_eq({tag, "_done"}, 64'(init_done), 64'(1));
    v = '0;
  endtask

  logic [N-1:0] both_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [W-1:0] strm_d [3];
  logic [AW-1:0] strm_a [3] = '{9'd8, 9'd5, 9'd6};

  initial begin
    strm_d[0] = 64'hAABBCCDD_00000000;
    strm_d[1] = ZI ? 64'h00000000_55667788 : 64'h00000000_55667788;
    strm_d[2] = ZI ? 64'h0 : MEM_INIT;
    reset = 1'b1; v = '0; w = '0; addr = '0; data = '0; mask = '0;
    req(0, 1'b1, 1'b0, 9'd5, '0, '1);
    req(1, 1'b1, 1'b1, 9'd6, '0, '1);
    tick(); tick(); #1;
    check_eq("rst_ready", 64'(ready), 64'(0));
    check_eq("rst_v_o", 64'(v_o), 64'(0));
    check_eq("rst_mem_v", 64'(mem_v), 64'(0));
    check_eq("rst_mem_w", 64'(mem_w), 64'(0));
    check_eq("rst_init_done", 64'(init_done), ZI ? 64'(0) : 64'(1));
    v = '0;
    reset = 1'b0;
`ifdef HARD_MEM_1RW_ARB_ZERO_INIT_EN
    sweep_check("sweep");
`endif

    // requester 0 write, low four bytes only
    req(0, 1'b1, 1'b1, 9'd5, 64'h11223344_55667788, 8'h0F);
    req(1, 1'b0, 1'b0, 9'd0, '0, '0);
    #1;
    check_eq("wr0_ready", 64'(ready), 64'(2'b01));
    check_eq("wr0_mem_v", 64'(mem_v), 64'(1));
    check_eq("wr0_mem_w", 64'(mem_w), 64'(1));
    check_eq("wr0_addr", 64'(mem_addr), 64'(5));
    check_eq("wr0_data", mem_data, 64'h11223344_55667788);
    check_eq("wr0_mask", 64'(mem_mask), 64'(8'h0F));
    tick();
    check_eq("wr0_no_resp", 64'(v_o), 64'(0));

    // requester 1 write, high four bytes only
    req(0, 1'b0, 1'b0, 9'd0, '0, '0);
    req(1, 1'b1, 1'b1, 9'd8, 64'hAABBCCDD_EEFF0011, 8'hF0);
    #1;
    check_eq("wr1_ready", 64'(ready), 64'(2'b10));
    check_eq("wr1_mask", 64'(mem_mask), 64'(8'hF0));
    tick();

    // requester 0 read-back; mask must be forced off
    req(0, 1'b1, 1'b0, 9'd5, '0, 8'hFF);
    req(1, 1'b0, 1'b0, 9'd0, '0, '0);
    #1;
    check_eq("rd0_ready", 64'(ready), 64'(2'b01));
    check_eq("rd0_mem_w", 64'(mem_w), 64'(0));
    check_eq("rd0_mask", 64'(mem_mask), 64'(0));
    tick();
    check_eq("rd0_v_o", 64'(v_o), 64'(2'b01));
    check_eq("rd0_data", data_o, 64'h00000000_55667788);

    // requester 1 streams alone
    req(0, 1'b0, 1'b0, 9'd0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      req(1, 1'b1, 1'b0, strm_a[i], '0, '0);
      #1;
      check_eq("strm_ready", 64'(ready), 64'(2'b10));
      tick();
      check_eq("strm_v_o", 64'(v_o), 64'(2'b10));
      check_eq("strm_data", data_o, strm_d[i]);
    end

    // idle cycle: nothing issued
    v = '0;
    #1;
    check_eq("idle_mem_v", 64'(mem_v), 64'(0));
    check_eq("idle_ready", 64'(ready), 64'(0));
    tick();
    check_eq("idle_v_o", 64'(v_o), 64'(0));

    // both requesters contend; requester 0 wins first
    req(0, 1'b1, 1'b0, 9'd5, '0, '0);
    req(1, 1'b1, 1'b0, 9'd8, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("both_ready", 64'(ready), 64'(both_g[i]));
      tick();
      check_eq("both_v_o", 64'(v_o), 64'(both_g[i]));
      check_eq("both_data", data_o, both_g[i][0] ? 64'h00000000_55667788 : 64'hAABBCCDD_00000000);
    end

    // read accepted, then reset on the following edge drops the response
    req(1, 1'b0, 1'b0, 9'd0, '0, '0);
    #1;
    check_eq("drop_ready", 64'(ready), 64'(2'b01));
    tick();
    reset = 1'b1;
    v = '0;
    #1;
    check_eq("drop_v_o", 64'(v_o), 64'(0));
    tick();
    check_eq("drop_v_o_after", 64'(v_o), 64'(0));
    reset = 1'b0;
`ifdef HARD_MEM_1RW_ARB_ZERO_INIT_EN
    #1;
    check_eq("restart_addr", 64'(mem_addr), 64'(0));
    check_eq("restart_mem_w", 64'(mem_w), 64'(1));
    repeat (200) tick();
    check_eq("mid_addr", 64'(mem_addr), 64'(200));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep_check("sweep_restart");
`endif

    // pointer returns to requester 0 after reset
    req(0, 1'b1, 1'b0, 9'd5, '0, '0);
    req(1, 1'b1, 1'b0, 9'd8, '0, '0);
    #1;
    check_eq("post_rst_grant", 64'(ready), 64'(2'b01));
    tick();
    v = '0;
    check_eq("post_rst_v_o", 64'(v_o), 64'(2'b01));
    check_eq("post_rst_data", data_o, ZI ? 64'h0 : 64'h00000000_55667788);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
